mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory-access pipeline stage between the execute stage and the write-back stage.
- Takes the decoded control bundle, the execute result (load/store address or ALU result) and the store operand from execute.
- Runs load/store transfers on a ready/ack data-memory port: byte-lane alignment, byte enables, sign/zero extension, access timeout.
- Presents a registered control bundle, execute result and aligned load data to write-back for one cycle.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles DMEM_REQ may stay high without DMEM_ACK before the access is aborted; legal range 1..65535.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RSTN  input  1  reset, asynchronous, active-low.
- IN_VALID  input  1  execute offers an instruction this cycle.
- IN_READY  output  1  stage can accept an instruction; high only in IDLE.
- CTR_INFO  input  control_info  decoded instruction flags (lb, lh, lw, lbu, lhu, sb, sh, sw, ALU ops, ...).
- EXEC_RD  input  32  execute result; effective address for loads/stores.
- RS2_DATA  input  32  store operand.
- DMEM_REQ  output  1  access request; held until DMEM_ACK.
- DMEM_WE  output  1  1 = store, 0 = load.
- DMEM_ADDR  output  32  word address, {EXEC_RD[31:2], 2'b00}.
- DMEM_BE  output  4  byte enables.
- DMEM_WDATA  output  32  lane-replicated store data.
- DMEM_ACK  input  1  access complete; read data valid the same cycle.
- DMEM_RDATA  input  32  read word.
- OUT_VALID  output  1  one-cycle pulse: output bundle valid.
- OUT_CTR_INFO  output  control_info  registered copy of CTR_INFO.
- OUT_EXEC_RD  output  32  registered EXEC_RD.
- MEMORY_OUT  output  32  aligned and extended load data; 0 for non-loads.
- MISALIGNED  output  1  qualifies OUT_VALID: access was misaligned.
- BUS_ERROR  output  1  qualifies OUT_VALID: access timed out.

Behaviour:
- Reset (RSTN low, asynchronous):
  - state IDLE, timeout counter 0.
  - All outputs 0 except IN_READY = 1; OUT_CTR_INFO all flags 0.
  - Reset during ACCESS drops DMEM_REQ immediately; no output is produced for the aborted instruction.
- FSM states: IDLE, ACCESS.
  - IDLE, accept (IN_VALID && IN_READY) of a non-memory op → stays IDLE; output registers load; OUT_VALID = 1 next cycle (latency 1).
  - IDLE, accept of an aligned load/store → ACCESS; the DMEM_* outputs are registered at accept.
  - IDLE, accept of a misaligned access → no request; OUT_VALID = 1 next cycle with MISALIGNED = 1 and MEMORY_OUT = 0.
  - Misaligned means: lh/lhu/sh with off[0] = 1, or lw/sw with off != 0, where off = EXEC_RD[1:0].
  - ACCESS: DMEM_REQ = 1, all DMEM_* outputs stable.
  - ACCESS + DMEM_ACK → IDLE; DMEM_REQ = 0 next cycle; OUT_VALID = 1 next cycle.
  - Total latency = 1 + number of ACCESS cycles; ack on the first ACCESS cycle gives OUT_VALID at accept + 2.
- Timeout counter:
  - Counts ACCESS cycles; cleared on entry to ACCESS.
  - Counter reaching TIMEOUT_CYCLES without an ack → IDLE; OUT_VALID with BUS_ERROR = 1, MEMORY_OUT = 0.
  - Ack in the same cycle as expiry: the ack wins, no error.
- DMEM_ACK while not in ACCESS is ignored.
- IN_VALID while IN_READY = 0 is ignored; upstream holds its data.
- OUT_VALID is a single-cycle pulse; write-back has no backpressure.
- A new accept is legal in the same cycle OUT_VALID is high.
- Between pulses the output registers hold their last values; OUT_VALID = 0.
- Byte enables (loads and stores alike):
  - byte ops: BE = 4'b0001 << off.
  - half ops: BE = 4'b0011 << off.
  - word ops: BE = 4'b1111.
- Store data:
  - sb: {4{RS2_DATA[7:0]}}.
  - sh: {2{RS2_DATA[15:0]}}.
  - sw: RS2_DATA.
  - DMEM_WE = 1 only for sb/sh/sw.
- Load extraction, from DMEM_RDATA captured on ack:
  - lb/lbu: byte at bit 8*off, sign/zero-extended.
  - lh/lhu: half at bit 8*off, sign/zero-extended.
  - lw: whole word.
- Stores produce MEMORY_OUT = 0.
- Write enable and write-data selection remain write-back's responsibility.

Decomposition:
- Shared def package holds:
  - control_info (existing);
  - mem_state_t enum {IDLE, ACCESS};
  - access-size enum {SZ_B, SZ_H, SZ_W};
  - the function that maps control_info to a load/store/size triple.
- Sub-module load_align (combinational): inputs RDATA, off, size, unsigned flag; output extended data.
- The FSM, counter and registers stay in mem_access_stage.

Test Plan:
- Non-memory: addi with EXEC_RD = 0x0000_0042 accepted at cycle T → OUT_VALID at T+1, OUT_EXEC_RD = 0x42, MEMORY_OUT = 0, DMEM_REQ never high.
- lb signed load: EXEC_RD = 0x1003, ack after 3 ACCESS cycles with RDATA = 0x80FF_1234.
  - DMEM_ADDR = 0x1000, BE = 4'b1000, WE = 0.
  - MEMORY_OUT = 0xFFFF_FF80.
  - lbu on the same data → 0x0000_0080.
- Stores:
  - sh, EXEC_RD = 0x2002, RS2_DATA = 0xDEAD_BEEF, ack immediately → BE = 4'b1100, WDATA = 0xBEEF_BEEF, WE = 1, OUT_VALID at T+2.
  - sw to 0x2001 → no DMEM_REQ; OUT_VALID at T+1 with MISALIGNED = 1.
- Timeout: TIMEOUT_CYCLES = 4, lw with no ack → DMEM_REQ high exactly 4 cycles, then OUT_VALID with BUS_ERROR = 1, MEMORY_OUT = 0.
  - Repeat with the ack on the 4th cycle → no error.
- Reset mid-access: RSTN low during the 2nd ACCESS cycle → DMEM_REQ = 0 asynchronously, IN_READY = 1, no OUT_VALID.
  - After release, lw to 0x3000 with RDATA = 0x1234_5678 completes normally with MEMORY_OUT = 0x1234_5678.
- Back-to-back and stall: IN_VALID held high with lw then add.
  - IN_READY is low during ACCESS; add is accepted on the cycle OUT_VALID pulses for lw.
  - add's OUT_VALID follows one cycle later.
  - A stray DMEM_ACK in IDLE has no effect.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared control bundle, stage state and memory-op decode.
package mem_access_stage_pkg;

  typedef struct packed {
    logic       reg_write;
    logic [4:0] rd;
    logic [3:0] alu_op;
    logic       is_alu;
    logic       lb;
    logic       lh;
    logic       lw;
    logic       lbu;
    logic       lhu;
    logic       sb;
    logic       sh;
    logic       sw;
  } control_info;

  typedef enum logic {IDLE, ACCESS} mem_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_t;

  typedef struct packed {
    logic      load;
    logic      store;
    acc_size_t size;
    logic      is_unsigned;
  } mem_op_t;

  function automatic mem_op_t decode_mem(input control_info c);
    mem_op_t m;
    m.load        = c.lb | c.lh | c.lw | c.lbu | c.lhu;
    m.store       = c.sb | c.sh | c.sw;
    m.size        = (c.lw | c.sw) ? SZ_W : (c.lh | c.lhu | c.sh) ? SZ_H : SZ_B;
    m.is_unsigned = c.lbu | c.lhu;
    return m;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: picks the addressed byte/half/word out of a read word and extends it.
module load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  acc_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b    = rdata[{off, 3'b000} +: 8];
    h    = rdata[{off[1], 4'b0000} +: 16];
    data = size == SZ_W ? rdata :
           size == SZ_H ? {{16{~is_unsigned & h[15]}}, h} :
                          {{24{~is_unsigned & b[7]}}, b};
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: execute-to-writeback stage running load/store transfers on a req/ack port.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  control_info CTR_INFO,
  input  logic [31:0] EXEC_RD,
  input  logic [31:0] RS2_DATA,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  input  logic        DMEM_ACK,
  input  logic [31:0] DMEM_RDATA,
  output logic        OUT_VALID,
  output control_info OUT_CTR_INFO,
  output logic [31:0] OUT_EXEC_RD,
  output logic [31:0] MEMORY_OUT,
  output logic        MISALIGNED,
  output logic        BUS_ERROR
);
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  mem_state_t  state;
  logic [15:0] cnt;
  mem_op_t     op;
  logic [1:0]  off;
  logic        is_mem;
  logic        misal;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] aligned;
  control_info p_ctr;
  logic [31:0] p_exec;
  logic        p_load;
  logic        p_uns;
  acc_size_t   p_size;
  logic [1:0]  p_off;

  always_comb begin
    op     = decode_mem(CTR_INFO);
    off    = EXEC_RD[1:0];
    is_mem = op.load | op.store;
    misal  = is_mem & ((op.size == SZ_H & off[0]) | (op.size == SZ_W & off != 2'b00));
    be     = op.size == SZ_W ? 4'b1111 : op.size == SZ_H ? 4'b0011 << off : 4'b0001 << off;
    wdata  = op.size == SZ_W ? RS2_DATA : op.size == SZ_H ? {2{RS2_DATA[15:0]}} : {4{RS2_DATA[7:0]}};
  end

  assign IN_READY = state == IDLE;

  load_align u_align (
    .rdata       (DMEM_RDATA),
    .off         (p_off),
    .size        (p_size),
    .is_unsigned (p_uns),
    .data        (aligned)
  );

  // Pending bundle is staged in p_* so the output registers only change on a pulse.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state        <= IDLE;
      cnt          <= '0;
      DMEM_REQ     <= 1'b0;
      DMEM_WE      <= 1'b0;
      DMEM_ADDR    <= '0;
      DMEM_BE      <= '0;
      DMEM_WDATA   <= '0;
      OUT_VALID    <= 1'b0;
      OUT_CTR_INFO <= '0;
      OUT_EXEC_RD  <= '0;
      MEMORY_OUT   <= '0;
      MISALIGNED   <= 1'b0;
      BUS_ERROR    <= 1'b0;
      p_ctr        <= '0;
      p_exec       <= '0;
      p_load       <= 1'b0;
      p_uns        <= 1'b0;
      p_size       <= SZ_B;
      p_off        <= '0;
    end else begin
      OUT_VALID <= 1'b0;
      if (state == IDLE) begin
        if (IN_VALID) begin
          if (is_mem && !misal) begin
            state      <= ACCESS;
            cnt        <= '0;
            DMEM_REQ   <= 1'b1;
            DMEM_WE    <= op.store;
            DMEM_ADDR  <= {EXEC_RD[31:2], 2'b00};
            DMEM_BE    <= be;
            DMEM_WDATA <= wdata;
            p_ctr      <= CTR_INFO;
            p_exec     <= EXEC_RD;
            p_load     <= op.load;
            p_uns      <= op.is_unsigned;
            p_size     <= op.size;
            p_off      <= off;
          end else begin
            OUT_VALID    <= 1'b1;
            OUT_CTR_INFO <= CTR_INFO;
            OUT_EXEC_RD  <= EXEC_RD;
            MEMORY_OUT   <= '0;
            MISALIGNED   <= misal;
            BUS_ERROR    <= 1'b0;
          end
        end
      end else if (DMEM_ACK || cnt == LAST) begin
        state        <= IDLE;
        DMEM_REQ     <= 1'b0;
        OUT_VALID    <= 1'b1;
        OUT_CTR_INFO <= p_ctr;
        OUT_EXEC_RD  <= p_exec;
        MEMORY_OUT   <= (DMEM_ACK && p_load) ? aligned : '0;
        MISALIGNED   <= 1'b0;
        BUS_ERROR    <= !DMEM_ACK;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end
endmodule
